// File: rtl/regfile_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_arbiter_if
// One requester's handshake with the register-file arbiter.
//   req    : access request, held with its fields until gnt is seen
//   we     : 1 = write, 0 = read
//   addr   : register address
//   wdata  : write data
//   gnt    : one-cycle pulse, request accepted and issued
//   rvalid : one-cycle pulse, shared read data is valid for this requester
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid
  );
endinterface

// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
// Serialises accesses from the control unit (CU) and the debug/loader port
// (DBG) onto a single-ported register file. CU has fixed priority; a
// starvation counter forces a DBG grant after STARVE_LIMIT consecutive
// DBG losses. Read data comes back on a shared bus qualified by rvalid.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   cu, dbg    : requester handshakes (req/we/addr/wdata in, gnt/rvalid out)
//   rdata      : shared read data, held until the next read completes
//   err        : pulse with gnt when the address is illegal (>= NUM_REGS)
//   rf_en      : register-file access strobe
//   rf_we      : register-file write enable
//   rf_addr    : register-file address
//   rf_wdata   : register-file write data
//   rf_rdata   : register-file read data, valid the cycle after a read strobe
//   busy       : high whenever the FSM is not in IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int NUM_REGS     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_arbiter_if.slave   cu,
  regfile_arbiter_if.slave   dbg,
  output logic [DATA_W-1:0]  rdata,
  output logic               err,
  output logic               rf_en,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_addr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W:0]   REGS_X     = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              owner_dbg_reg, owner_dbg_next;
  logic              illegal_reg, illegal_next;

  logic              cu_gnt_reg, cu_gnt_next;
  logic              dbg_gnt_reg, dbg_gnt_next;
  logic              cu_rvalid_reg, cu_rvalid_next;
  logic              dbg_rvalid_reg, dbg_rvalid_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic              rf_en_reg, rf_en_next;
  logic              rf_we_reg, rf_we_next;
  logic [ADDR_W-1:0] rf_addr_reg, rf_addr_next;
  logic [DATA_W-1:0] rf_wdata_reg, rf_wdata_next;
  logic              busy_reg, busy_next;

  logic starve_full;
  logic dbg_wins;
  logic selecting;

  assign starve_full = (starve_cnt_reg == STARVE_MAX);
  // DBG takes the slot when it is alone or when it has lost too often.
  assign dbg_wins    = dbg.req && (!cu.req || starve_full);

  // -------------------------------------------------------------------------
  // State register (also holds every registered output)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      owner_dbg_reg  <= 1'b0;
      illegal_reg    <= 1'b0;
      cu_gnt_reg     <= 1'b0;
      dbg_gnt_reg    <= 1'b0;
      cu_rvalid_reg  <= 1'b0;
      dbg_rvalid_reg <= 1'b0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      rf_en_reg      <= 1'b0;
      rf_we_reg      <= 1'b0;
      rf_addr_reg    <= '0;
      rf_wdata_reg   <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      owner_dbg_reg  <= owner_dbg_next;
      illegal_reg    <= illegal_next;
      cu_gnt_reg     <= cu_gnt_next;
      dbg_gnt_reg    <= dbg_gnt_next;
      cu_rvalid_reg  <= cu_rvalid_next;
      dbg_rvalid_reg <= dbg_rvalid_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
      rf_en_reg      <= rf_en_next;
      rf_we_reg      <= rf_we_next;
      rf_addr_reg    <= rf_addr_next;
      rf_wdata_reg   <= rf_wdata_next;
      busy_reg       <= busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: arbitration, field latching, starvation counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    owner_dbg_next  = owner_dbg_reg;
    illegal_next    = illegal_reg;

    case (state_reg)
      IDLE: begin
        if (!dbg.req) starve_cnt_next = '0;
        if (cu.req || dbg.req) begin
          state_next     = ISSUE;
          owner_dbg_next = dbg_wins;
          if (dbg_wins) begin
            we_next         = dbg.we;
            addr_next       = dbg.addr;
            wdata_next      = dbg.wdata;
            starve_cnt_next = '0;
          end else begin
            we_next    = cu.we;
            addr_next  = cu.addr;
            wdata_next = cu.wdata;
            // A DBG request lost to CU: count it, saturating.
            if (dbg.req && !starve_full)
              starve_cnt_next = starve_cnt_reg + CNT_W'(1);
          end
          illegal_next = ({1'b0, addr_next} >= REGS_X);
        end
      end
      ISSUE:   state_next = we_reg ? IDLE : RDATA;
      RDATA:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: values computed one cycle early so that every output
  // leaves a flop. ISSUE-cycle strobes are loaded at the selection edge,
  // rvalid/rdata at the end of RDATA.
  // -------------------------------------------------------------------------
  assign selecting = (state_reg == IDLE) && (state_next == ISSUE);

  always_comb begin
    cu_gnt_next     = 1'b0;
    dbg_gnt_next    = 1'b0;
    cu_rvalid_next  = 1'b0;
    dbg_rvalid_next = 1'b0;
    err_next        = 1'b0;
    rf_en_next      = 1'b0;
    rf_we_next      = 1'b0;
    rf_addr_next    = rf_addr_reg;
    rf_wdata_next   = rf_wdata_reg;
    rdata_next      = rdata_reg;
    busy_next       = (state_next != IDLE);

    if (selecting) begin
      cu_gnt_next   = !owner_dbg_next;
      dbg_gnt_next  = owner_dbg_next;
      rf_en_next    = !illegal_next;
      rf_we_next    = we_next;
      rf_addr_next  = addr_next;
      rf_wdata_next = wdata_next;
      err_next      = illegal_next;
    end

    if (state_reg == RDATA) begin
      cu_rvalid_next  = !owner_dbg_reg;
      dbg_rvalid_next = owner_dbg_reg;
      // Illegal addresses never strobed the file, so return zero instead.
      rdata_next      = illegal_reg ? '0 : rf_rdata;
    end
  end

  assign cu.gnt     = cu_gnt_reg;
  assign dbg.gnt    = dbg_gnt_reg;
  assign cu.rvalid  = cu_rvalid_reg;
  assign dbg.rvalid = dbg_rvalid_reg;
  assign rdata      = rdata_reg;
  assign err        = err_reg;
  assign rf_en      = rf_en_reg;
  assign rf_we      = rf_we_reg;
  assign rf_addr    = rf_addr_reg;
  assign rf_wdata   = rf_wdata_reg;
  assign busy       = busy_reg;

endmodule
